// File: rtl/ra_mul_sched.sv
// rtl/ra_mul_sched.sv - round-robin scheduler for a shared repeated-addition multiplier
// Two requesters share one accumulate/count loop; product returned with requester id.
module ra_mul_sched #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic [1:0]         gnt,
  output logic               busy,
  output logic               cntclr,
  output logic               cnten,
  output logic               done,
  output logic               done_id,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state, nstate;
  logic [WIDTH-1:0]   a_sel, b_sel, cnt;
  logic [2*WIDTH-1:0] acc;
  logic               owner, rr, pick;

  // Contention goes to the rr pointer; otherwise req1 wins only if it is the sole requester.
  assign pick = (req0 && req1) ? rr : req1;

  always_comb begin
    nstate  = state;
    busy    = (state != IDLE);
    cntclr  = 1'b0;
    cnten   = 1'b0;
    done    = 1'b0;
    done_id = 1'b0;
    case (state)
      IDLE: if (req0 || req1) nstate = LOAD;
      LOAD: begin
        cntclr = 1'b1;
        nstate = ADD;
      end
      ADD: begin
        if (cnt == b_sel) nstate = DONE;
        else              cnten  = 1'b1;
      end
      DONE: begin
        done    = 1'b1;
        done_id = owner;
        nstate  = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state   <= IDLE;
      gnt     <= 2'b00;
      owner   <= 1'b0;
      rr      <= 1'b0;
      a_sel   <= '0;
      b_sel   <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= nstate;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner <= pick;
            a_sel <= pick ? a1 : a0;
            b_sel <= pick ? b1 : b0;
            gnt   <= pick ? 2'b10 : 2'b01;
          end
        end
        LOAD: begin
          acc <= '0;
          cnt <= '0;
        end
        ADD: begin
          // Product is captured on entry to DONE so it is valid alongside the done pulse.
          if (cnt == b_sel) begin
            product <= acc;
          end else begin
            acc <= acc + {{WIDTH{1'b0}}, a_sel};
            cnt <= cnt + {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          rr  <= ~owner;
          gnt <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ra_mul_sched.sv
// tb/tb_ra_mul_sched.sv - directed scoreboard bench for ra_mul_sched
module tb_ra_mul_sched;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             clear;
  logic             req0, req1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic [1:0]       gnt;
  logic             busy, cntclr, cnten, done, done_id;
  logic [7:0]       product;

  typedef struct {
    logic       id;
    logic [7:0] p;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  ra_mul_sched #(.WIDTH(WIDTH)) dut (
    .clk(clk), .clear(clear),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt(gnt), .busy(busy), .cntclr(cntclr), .cnten(cnten),
    .done(done), .done_id(done_id), .product(product)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic push(input logic id, input int p);
    exp_t e;
    e.id = id;
    e.p  = 8'(p);
    sb.push_back(e);
  endtask

  // Waits for done (bounded), then pops the scoreboard and checks the result.
  task automatic expect_done(input string tag, input int exp_lat, input int exp_cn);
    int   lat = 0;
    int   ncn = 0;
    logic seen = 1'b0;
    exp_t e;
    for (int i = 0; i < 100; i++) begin
      tick();
      lat++;
      if (cnten) ncn++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_product"}, 32'(product), 32'(e.p));
    chk({tag, "_done_id"}, 32'(done_id), 32'(e.id));
    chk({tag, "_gnt"}, 32'(gnt), e.id ? 32'd2 : 32'd1);
    if (exp_lat >= 0) chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (exp_cn >= 0)  chk({tag, "_cnten"}, 32'(ncn), 32'(exp_cn));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    clear = 1'b0;
    tick();
  endtask

  initial begin
    int ndone;
    clear = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cntclr", 32'(cntclr), 32'd0);
    chk("rst_cnten", 32'(cnten), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    clear = 1'b0;
    tick();

    // single requester 8*3
    req0 = 1'b1; a0 = 4'd8; b0 = 4'd3;
    push(1'b0, 24);
    tick();
    chk("t1_gnt_load", 32'(gnt), 32'd1);
    chk("t1_cntclr", 32'(cntclr), 32'd1);
    expect_done("t1", 5, 3);
    req0 = 1'b0;
    tick(); tick();

    // simultaneous requests from reset: req0 first, then req1
    do_clear();
    req0 = 1'b1; a0 = 4'd7; b0 = 4'd4;
    req1 = 1'b1; a1 = 4'd15; b1 = 4'd15;
    push(1'b0, 28);
    push(1'b1, 225);
    expect_done("t2a", 7, 4);
    req0 = 1'b0;
    expect_done("t2b", 19, 15);
    req1 = 1'b0;
    tick(); tick();

    // both held: grants alternate
    do_clear();
    req0 = 1'b1; a0 = 4'd2; b0 = 4'd1;
    req1 = 1'b1; a1 = 4'd3; b1 = 4'd2;
    push(1'b0, 2); push(1'b1, 6); push(1'b0, 2); push(1'b1, 6);
    expect_done("t3a", 4, 1);
    expect_done("t3b", 6, 2);
    expect_done("t3c", 5, 1);
    expect_done("t3d", 6, 2);
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();

    // b=0: no adds, done two edges after sampling
    req1 = 1'b1; a1 = 4'd9; b1 = 4'd0;
    push(1'b1, 0);
    expect_done("t4", 3, 0);
    req1 = 1'b0;
    tick(); tick();

    // operand change and req drop mid-ADD are ignored
    req0 = 1'b1; a0 = 4'd5; b0 = 4'd2;
    push(1'b0, 10);
    tick(); tick();
    chk("t6_busy_add", 32'(busy), 32'd1);
    a0 = 4'd15; b0 = 4'd15; req0 = 1'b0;
    expect_done("t6", 3, -1);
    tick(); tick();

    // clear during ADD of 8*3
    req0 = 1'b1; a0 = 4'd8; b0 = 4'd3;
    tick(); tick(); tick();
    chk("t5_cnten_pre", 32'(cnten), 32'd1);
    clear = 1'b1;
    tick();
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_gnt", 32'(gnt), 32'd0);
    chk("t5_product", 32'(product), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    clear = 1'b0; req0 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("t5_no_done", 32'(ndone), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
